fetch_pc_gen: RTL and testbench

- Instruction-fetch front end that owns the architectural fetch PC.
- Presents the PC to the branch target buffer and consumes its prediction (match/next PC) and its execute-stage correction (update event).
- Issues in-order requests to instruction memory and buffers the returned instructions with their PC and predicted next PC until decode accepts them.
- On a correction, flushes everything in flight and drops stale memory responses.

---
 rtl/fetch_pc_gen.sv | 148 ++++++++++++++
 tb/tb_fetch_pc_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Instruction-fetch front end: owns the fetch PC, consults the BTB, issues
// in-order memory requests and buffers returned instructions for decode.
// Redirects flush the buffer and discard responses still in flight.

package maverickOne_pkg;
    localparam int XLEN = 32;
endpackage

module fetch_pc_gen #(
    parameter int              XLEN      = maverickOne_pkg::XLEN,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] BOOT_ADDR = '0
) (
    input  logic            clk_i,
    input  logic            arst_ni,
    output logic [XLEN-1:0] btb_pc_o,
    input  logic            btb_match_i,
    input  logic [XLEN-1:0] btb_next_pc_i,
    input  logic            btb_update_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [XLEN-1:0] instr_pred_pc_o
);
    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [PW:0] ptr_t;

    logic [XLEN-1:0] pc_q, pc_d;
    ptr_t            wr_ptr_q, wr_ptr_d;
    ptr_t            fill_ptr_q, fill_ptr_d;
    ptr_t            rd_ptr_q, rd_ptr_d;
    ptr_t            drop_cnt_q, drop_cnt_d;
    logic [DEPTH-1:0] ent_done_q;

    logic [XLEN-1:0] ent_pc_q    [DEPTH];
    logic [XLEN-1:0] ent_pred_q  [DEPTH];
    logic [31:0]     ent_instr_q [DEPTH];

    ptr_t            occ;
    ptr_t            pending;
    logic [PW+1:0]   budget;
    logic [XLEN-1:0] pred;
    logic            issue;
    logic            rsp_drop;
    logic            rsp_fill;
    logic            head_done;
    logic            out_fire;
    logic [PW-1:0]   wr_idx, fill_idx, rd_idx;

    assign wr_idx   = wr_ptr_q[PW-1:0];
    assign fill_idx = fill_ptr_q[PW-1:0];
    assign rd_idx   = rd_ptr_q[PW-1:0];

    assign occ     = wr_ptr_q - rd_ptr_q;
    assign pending = wr_ptr_q - fill_ptr_q;
    // Requests still owed by memory (live or to be dropped) never exceed DEPTH.
    assign budget  = {1'b0, occ} + {1'b0, drop_cnt_q};

    assign pred = btb_match_i ? btb_next_pc_i : pc_q + XLEN'(4);

    // While reset is held the PC outputs already show the boot address.
    assign btb_pc_o    = arst_ni ? pc_q : BOOT_ADDR;
    assign imem_addr_o = btb_pc_o;

    assign imem_req_valid_o = arst_ni & ~btb_update_i & (budget < (PW+2)'(DEPTH));
    assign issue            = imem_req_valid_o & imem_req_ready_i;

    assign rsp_drop = imem_rsp_valid_i & (drop_cnt_q != '0);
    assign rsp_fill = imem_rsp_valid_i & (drop_cnt_q == '0) & (pending != '0);

    assign head_done       = (occ != '0) & ent_done_q[rd_idx];
    assign instr_valid_o   = arst_ni & ~btb_update_i & head_done;
    assign out_fire        = instr_valid_o & instr_ready_i;
    assign instr_o         = ent_instr_q[rd_idx];
    assign instr_pc_o      = ent_pc_q[rd_idx];
    assign instr_pred_pc_o = ent_pred_q[rd_idx];

    // Next-state for PC, pointers and drop counter; redirect overrides all.
    always_comb begin
        pc_d       = pc_q;
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        if (btb_update_i) begin
            pc_d       = btb_next_pc_i;
            fill_ptr_d = wr_ptr_q;
            rd_ptr_d   = wr_ptr_q;
            // A response this cycle either retires an old drop or a pending
            // entry; both shrink the set still owed by one.
            drop_cnt_d = drop_cnt_q + pending - {{PW{1'b0}}, (rsp_drop | rsp_fill)};
        end else begin
            if (issue) begin
                pc_d     = pred;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rsp_drop) drop_cnt_d = drop_cnt_q - 1'b1;
            if (rsp_fill) fill_ptr_d = fill_ptr_q + 1'b1;
            if (out_fire) rd_ptr_d   = rd_ptr_q + 1'b1;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            pc_q       <= BOOT_ADDR;
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
            ent_done_q <= '0;
        end else begin
            pc_q       <= pc_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
            if (!btb_update_i) begin
                if (issue)    ent_done_q[wr_idx]   <= 1'b0;
                if (rsp_fill) ent_done_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Entry payload; validity is tracked by pointers and done bits only.
    always_ff @(posedge clk_i) begin
        if (!btb_update_i) begin
            if (issue) begin
                ent_pc_q[wr_idx]   <= pc_q;
                ent_pred_q[wr_idx] <= pred;
            end
            if (rsp_fill) ent_instr_q[fill_idx] <= imem_rsp_data_i;
        end
    end

    // A response with nothing pending and nothing to drop breaks the protocol.
    a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (!arst_ni)
        !(imem_rsp_valid_i && drop_cnt_q == '0 && pending == '0));

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with a queue-based in-order memory model.
module tb_fetch_pc_gen;
    logic        clk_i = 1'b0;
    logic        arst_ni;
    logic [31:0] btb_pc_o;
    logic        btb_match_i;
    logic [31:0] btb_next_pc_i;
    logic        btb_update_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [31:0] instr_pred_pc_o;

    int total = 0;
    int bad   = 0;

    logic        mem_en;
    logic [31:0] mq [$];
    logic [31:0] iss_log [$];
    logic [31:0] dpc [$];
    logic [31:0] dpred [$];
    logic [31:0] dins [$];

    logic        s_req_v, s_ivalid;
    logic [31:0] s_addr, s_btb_pc, s_ipc, s_ipred, s_instr;

    always #5 clk_i = ~clk_i;

    fetch_pc_gen #(.DEPTH(4), .BOOT_ADDR(32'h0000_1000)) dut (
        .clk_i           (clk_i),
        .arst_ni         (arst_ni),
        .btb_pc_o        (btb_pc_o),
        .btb_match_i     (btb_match_i),
        .btb_next_pc_i   (btb_next_pc_i),
        .btb_update_i    (btb_update_i),
        .imem_req_valid_o(imem_req_valid_o),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_addr_o     (imem_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i (imem_rsp_data_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_pred_pc_o (instr_pred_pc_o)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // One clock: sample outputs at negedge, then let memory answer after the edge.
    task automatic step();
        @(negedge clk_i);
        s_req_v  = imem_req_valid_o;
        s_addr   = imem_addr_o;
        s_btb_pc = btb_pc_o;
        s_ivalid = instr_valid_o;
        s_ipc    = instr_pc_o;
        s_ipred  = instr_pred_pc_o;
        s_instr  = instr_o;
        if (s_req_v && imem_req_ready_i) iss_log.push_back(s_addr);
        if (s_ivalid && instr_ready_i) begin
            dpc.push_back(s_ipc);
            dpred.push_back(s_ipred);
            dins.push_back(s_instr);
        end
        @(posedge clk_i);
        #1;
        imem_rsp_valid_i = 1'b0;
        if (!arst_ni) begin
            mq.delete();
        end else begin
            if (s_req_v && imem_req_ready_i) mq.push_back(s_addr);
            if (mem_en && mq.size() > 0) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = mdata(mq.pop_front());
            end
        end
    endtask

    task automatic clear_logs();
        iss_log.delete(); dpc.delete(); dpred.delete(); dins.delete();
    endtask

    task automatic set_defaults();
        btb_match_i = 0; btb_next_pc_i = '0; btb_update_i = 0;
        imem_req_ready_i = 1; instr_ready_i = 1; mem_en = 1;
    endtask

    task automatic do_reset();
        arst_ni = 0;
        set_defaults();
        step(); step();
        arst_ni = 1;
        clear_logs();
    endtask

    task automatic test_reset();
        arst_ni = 0;
        set_defaults();
        step(); step();
        total++; if (s_req_v !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", s_req_v); end
        total++; if (s_ivalid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b exp=0", s_ivalid); end
        total++; if (s_btb_pc !== 32'h1000) begin bad++; $display("FAIL reset_btb_pc got=%h exp=00001000", s_btb_pc); end
        total++; if (s_addr !== 32'h1000) begin bad++; $display("FAIL reset_addr got=%h exp=00001000", s_addr); end
        arst_ni = 1;
        step();
        total++; if (s_req_v !== 1'b1 || s_addr !== 32'h1000) begin bad++; $display("FAIL first_req got=%b/%h exp=1/00001000", s_req_v, s_addr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (6) step();
        total++; if (iss_log.size() != 6) begin bad++; $display("FAIL b2b_issue_count got=%0d exp=6", iss_log.size()); end
        for (int i = 0; i < 6 && i < iss_log.size(); i++) begin
            total++; if (iss_log[i] !== 32'h1000 + 32'(4*i)) begin bad++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, iss_log[i], 32'h1000 + 32'(4*i)); end
        end
        total++; if (dpc.size() != 4) begin bad++; $display("FAIL b2b_deliver_count got=%0d exp=4", dpc.size()); end
        for (int k = 0; k < 4 && k < dpc.size(); k++) begin
            total++; if (dpc[k] !== 32'h1000 + 32'(4*k)) begin bad++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", k, dpc[k], 32'h1000 + 32'(4*k)); end
            total++; if (dpred[k] !== 32'h1004 + 32'(4*k)) begin bad++; $display("FAIL b2b_pred[%0d] got=%h exp=%h", k, dpred[k], 32'h1004 + 32'(4*k)); end
            total++; if (dins[k] !== mdata(32'h1000 + 32'(4*k))) begin bad++; $display("FAIL b2b_instr[%0d] got=%h exp=%h", k, dins[k], mdata(32'h1000 + 32'(4*k))); end
        end
    endtask

    task automatic test_btb_hit();
        do_reset();
        step(); step();
        btb_match_i = 1; btb_next_pc_i = 32'h2000;
        step();
        total++; if (s_btb_pc !== 32'h1008) begin bad++; $display("FAIL hit_btb_pc got=%h exp=00001008", s_btb_pc); end
        btb_match_i = 0;
        step(); step();
        total++; if (iss_log.size() != 5) begin bad++; $display("FAIL hit_issue_count got=%0d exp=5", iss_log.size()); end
        else begin
            total++; if (iss_log[3] !== 32'h2000) begin bad++; $display("FAIL hit_target got=%h exp=00002000", iss_log[3]); end
            total++; if (iss_log[4] !== 32'h2004) begin bad++; $display("FAIL hit_after got=%h exp=00002004", iss_log[4]); end
        end
        total++; if (dpc.size() != 3) begin bad++; $display("FAIL hit_deliver_count got=%0d exp=3", dpc.size()); end
        else begin
            total++; if (dpc[2] !== 32'h1008 || dpred[2] !== 32'h2000) begin bad++; $display("FAIL hit_entry got=%h/%h exp=00001008/00002000", dpc[2], dpred[2]); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        instr_ready_i = 0;
        repeat (8) step();
        total++; if (iss_log.size() != 4) begin bad++; $display("FAIL stall_issue_count got=%0d exp=4", iss_log.size()); end
        total++; if (s_req_v !== 1'b0) begin bad++; $display("FAIL stall_req_blocked got=%b exp=0", s_req_v); end
        instr_ready_i = 1;
        step();
        total++; if (s_req_v !== 1'b0 || s_ivalid !== 1'b1 || s_ipc !== 32'h1000) begin bad++; $display("FAIL stall_drain got=%b/%b/%h exp=0/1/00001000", s_req_v, s_ivalid, s_ipc); end
        step();
        total++; if (s_req_v !== 1'b1 || s_addr !== 32'h1010) begin bad++; $display("FAIL stall_resume got=%b/%h exp=1/00001010", s_req_v, s_addr); end
    endtask

    task automatic test_redirect();
        do_reset();
        mem_en = 0;
        repeat (3) step();
        total++; if (iss_log.size() != 3) begin bad++; $display("FAIL redir_outstanding got=%0d exp=3", iss_log.size()); end
        btb_update_i = 1; btb_match_i = 1; btb_next_pc_i = 32'h3000; mem_en = 1;
        step();
        total++; if (s_req_v !== 1'b0 || s_ivalid !== 1'b0) begin bad++; $display("FAIL redir_cycle_idle got=%b/%b exp=0/0", s_req_v, s_ivalid); end
        btb_update_i = 0; btb_match_i = 0;
        step();
        total++; if (s_req_v !== 1'b1 || s_addr !== 32'h3000) begin bad++; $display("FAIL redir_first_req got=%b/%h exp=1/00003000", s_req_v, s_addr); end
        repeat (5) step();
        total++; if (dpc.size() != 2) begin bad++; $display("FAIL redir_deliver_count got=%0d exp=2", dpc.size()); end
        else begin
            total++; if (dpc[0] !== 32'h3000 || dins[0] !== mdata(32'h3000)) begin bad++; $display("FAIL redir_first_instr got=%h/%h exp=00003000/%h", dpc[0], dins[0], mdata(32'h3000)); end
            total++; if (dpc[1] !== 32'h3004 || dins[1] !== mdata(32'h3004)) begin bad++; $display("FAIL redir_second_instr got=%h/%h exp=00003004/%h", dpc[1], dins[1], mdata(32'h3004)); end
        end
    endtask

    task automatic test_redirect_rsp();
        do_reset();
        mem_en = 0;
        step();
        mem_en = 1;
        step();
        mem_en = 0; imem_req_ready_i = 0; btb_update_i = 1; btb_next_pc_i = 32'h4000;
        step();
        total++; if (s_req_v !== 1'b0 || s_ivalid !== 1'b0) begin bad++; $display("FAIL rrsp_cycle_idle got=%b/%b exp=0/0", s_req_v, s_ivalid); end
        btb_update_i = 0; imem_req_ready_i = 1; mem_en = 1;
        step();
        total++; if (s_req_v !== 1'b1 || s_addr !== 32'h4000) begin bad++; $display("FAIL rrsp_first_req got=%b/%h exp=1/00004000", s_req_v, s_addr); end
        repeat (4) step();
        total++; if (dpc.size() != 2) begin bad++; $display("FAIL rrsp_deliver_count got=%0d exp=2", dpc.size()); end
        else begin
            total++; if (dpc[0] !== 32'h4000 || dins[0] !== mdata(32'h4000)) begin bad++; $display("FAIL rrsp_first_instr got=%h/%h exp=00004000/%h", dpc[0], dins[0], mdata(32'h4000)); end
            total++; if (dins[1] !== mdata(32'h4004)) begin bad++; $display("FAIL rrsp_second_instr got=%h exp=%h", dins[1], mdata(32'h4004)); end
        end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        btb_update_i = 1; btb_next_pc_i = 32'hFFFF_FFFC;
        step();
        btb_update_i = 0;
        step();
        total++; if (s_req_v !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%b/%h exp=1/fffffffc", s_req_v, s_addr); end
        step();
        total++; if (s_req_v !== 1'b1 || s_addr !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%b/%h exp=1/00000000", s_req_v, s_addr); end
        step();
        total++; if (s_ivalid !== 1'b1 || s_ipc !== 32'hFFFF_FFFC || s_ipred !== 32'h0) begin bad++; $display("FAIL wrap_pred got=%b/%h/%h exp=1/fffffffc/00000000", s_ivalid, s_ipc, s_ipred); end
        btb_update_i = 1; btb_next_pc_i = 32'h5000;
        step();
        total++; if (s_ivalid !== 1'b0 || s_req_v !== 1'b0) begin bad++; $display("FAIL redir_gates_valid got=%b/%b exp=0/0", s_ivalid, s_req_v); end
        btb_update_i = 0;
        arst_ni = 0;
        step();
        total++; if (s_req_v !== 1'b0 || s_ivalid !== 1'b0 || s_btb_pc !== 32'h1000) begin bad++; $display("FAIL midreset_idle got=%b/%b/%h exp=0/0/00001000", s_req_v, s_ivalid, s_btb_pc); end
        step();
        arst_ni = 1;
        step();
        total++; if (s_req_v !== 1'b1 || s_addr !== 32'h1000 || s_ivalid !== 1'b0) begin bad++; $display("FAIL midreset_restart got=%b/%h/%b exp=1/00001000/0", s_req_v, s_addr, s_ivalid); end
    endtask

    initial begin
        arst_ni = 0;
        imem_rsp_valid_i = 0;
        imem_rsp_data_i = '0;
        set_defaults();
        test_reset();
        test_back_to_back();
        test_btb_hit();
        test_stall();
        test_redirect();
        test_redirect_rsp();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
